m6809_reset_halt_ctl: RTL
=========================

# m6809_reset_halt_ctl

CPU-side controller that answers the SoC's external `reset_b` / `halt_b` controls for the m6809 core. On reset release it fetches the reset vector through the core's memory port and loads the PC. It gates the core's run enable and pauses the core at an instruction boundary on halt. It drives the 6809 BA/BS status pins so the rest of `m6809_integration` can see the bus state.

## Interface
Parameters:
- `RST_VEC_ADDR`, 16'hFFFE: address of vector high byte; low byte is read from `RST_VEC_ADDR+1`.
- `MEM_LATENCY`, 1: edges from the `rd` cycle to valid `data_in`; legal range 1..3.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset_b`  in  1  **synchronous, active-low** reset.
- `halt_b`  in  1  active-low halt request.
- `inst_done`  in  1  core is at an instruction boundary this cycle.
- `data_in`  in  8  memory read data.
- `addr`  out  16  vector-fetch address; 0 when not fetching.
- `rd`  out  1  one-cycle read strobe.
- `pc_load`  out  1  one-cycle PC load pulse.
- `pc_value`  out  16  fetched vector; held after load.
- `core_run`  out  1  core may advance.
- `ba`, `bs`  out  1 each  6809 bus status.

## Operation
- States: RESET, VEC_HI, WAIT_HI, VEC_LO, WAIT_LO, LOAD, RUN, HALT_WAIT, HALTED.
- BA/BS encoding:
  - 00: run.
  - 01: reset/vector acknowledge, held in RESET through LOAD.
  - 11: halted.
  - 10: unused.
- `reset_b`=0 at any edge, from any state (including mid-fetch):
  - Next state is RESET.
  - Outputs: `addr`=0, `rd`=0, `pc_load`=0, `pc_value`=0, `core_run`=0, `ba`=0, `bs`=1.
  - Latency counter and vector register clear.
- RESET→VEC_HI on the first edge sampling `reset_b`=1.
- VEC_HI: `rd`=1 and `addr`=RST_VEC_ADDR for exactly one cycle, then WAIT_HI.
- WAIT_HI: counts `MEM_LATENCY` edges from the end of the `rd` cycle and captures `data_in` into `pc_value[15:8]` on the final one.
- VEC_LO / WAIT_LO: same sequence with `addr`=RST_VEC_ADDR+1, capturing `pc_value[7:0]`. The address add wraps modulo 2^16.
- LOAD: `pc_load`=1 for one cycle, then RUN.
- RUN: `core_run`=1, BA/BS=00.
  - `halt_b`=0 and `inst_done`=0: go to HALT_WAIT.
  - `halt_b`=0 and `inst_done`=1: go directly to HALTED.
- HALT_WAIT: `core_run` stays 1.
  - `inst_done`=1: go to HALTED.
  - `halt_b` returns to 1 before `inst_done`: go back to RUN.
  - If both happen on the same edge, `inst_done` wins and the next state is HALTED.
- HALTED: `core_run`=0, BA/BS=11. `halt_b`=1 returns to RUN (BA/BS=00, `core_run`=1) on the next cycle.
- `halt_b` during RESET…LOAD is ignored; the vector fetch always completes.
  - If `halt_b` is still 0 on entry to RUN, the next state is HALTED, because the core sits at a boundary before its first instruction.
- All outputs are registered and come directly from state or capture registers.

## Timing
- E0 is the first edge sampling `reset_b`=1.
- `rd` is high during cycle E0→E1 and again during E(1+L)→E(2+L), where L=`MEM_LATENCY`.
- Captures occur at E(1+L) and E(2+2L).
- `pc_load` is high during E(2+2L)→E(3+2L); `core_run` rises at E(3+2L). With L=1: `pc_load` at E4→E5, run from E5.
- Halt entry: BA/BS=11 and `core_run`=0 in the cycle after the edge that samples `inst_done`=1 (or `halt_b`=0, if already at a boundary). Minimum latency is 1 cycle.
- Halt exit: 1 cycle after `halt_b`=1 is sampled. With the synchronizer, add 2 cycles to both halt entry and exit.

## Configuration
- `M6809_HALT_SYNC_EN` defined: `halt_b` passes through a two-flop synchronizer.
  - Synchronizer reset value is 1 (not halted).
  - Every halt-related latency grows by 2 cycles.
- Not defined: `halt_b` is sampled directly and treated as synchronous to `clk`.

## Structure
- Shared `m6809_pkg` holds:
  - the state encoding (4-bit localparams);
  - the BA/BS encodings: BABS_RUN=2'b00, BABS_ACK=2'b01, BABS_HALT=2'b11;
  - the default vector address.
- One sub-module: `m6809_sync2`, the 2-flop synchronizer with a reset value parameter. It is instantiated only under `M6809_HALT_SYNC_EN`.

## Test plan
- Reset vector fetch:
  - Stimulus: memory returns 8'hC0 at FFFE and 8'h10 at FFFF, L=1; release reset.
  - Required: `rd` pulses at FFFE then FFFF; `pc_load` for one cycle with `pc_value`=16'hC010; `core_run`=1 at E5; BA/BS goes 01→00.
- Latency sweep:
  - Stimulus: L=3 with the same data.
  - Required: `pc_load` at E8; second `rd` at E4.
- Halt handshake:
  - Stimulus: in RUN, `halt_b`=0, then `inst_done` 3 cycles later.
  - Required: `core_run` stays 1 for those 3 cycles, then 0 with BA/BS=11.
  - Then `halt_b`=1; required: run and BA/BS=00 one cycle later.
- Halt aborted:
  - Stimulus: `halt_b` low 2 cycles, then high, with no `inst_done`.
  - Required: back to RUN; BA/BS never 11.
- Halt held through reset:
  - Stimulus: `halt_b`=0 throughout reset release.
  - Required: full vector fetch completes; HALTED entered right after LOAD, with `core_run` never 1.
- Reset mid-fetch:
  - Stimulus: `reset_b`=0 during WAIT_LO.
  - Required: all outputs return to their reset values next cycle; on release, the fetch restarts at FFFE.

Source files
------------

// File: rtl/m6809_pkg.sv
// Shared definitions for the m6809 reset/halt controller: state encoding,
// BA/BS status encodings and the default reset-vector address.
package m6809_pkg;

    localparam logic [3:0] ST_RESET     = 4'd0;
    localparam logic [3:0] ST_VEC_HI    = 4'd1;
    localparam logic [3:0] ST_WAIT_HI   = 4'd2;
    localparam logic [3:0] ST_VEC_LO    = 4'd3;
    localparam logic [3:0] ST_WAIT_LO   = 4'd4;
    localparam logic [3:0] ST_LOAD      = 4'd5;
    localparam logic [3:0] ST_RUN       = 4'd6;
    localparam logic [3:0] ST_HALT_WAIT = 4'd7;
    localparam logic [3:0] ST_HALTED    = 4'd8;

    typedef enum logic [3:0] {
        S_RESET     = ST_RESET,
        S_VEC_HI    = ST_VEC_HI,
        S_WAIT_HI   = ST_WAIT_HI,
        S_VEC_LO    = ST_VEC_LO,
        S_WAIT_LO   = ST_WAIT_LO,
        S_LOAD      = ST_LOAD,
        S_RUN       = ST_RUN,
        S_HALT_WAIT = ST_HALT_WAIT,
        S_HALTED    = ST_HALTED
    } state_t;

    // {ba, bs}
    localparam logic [1:0] BABS_RUN  = 2'b00;
    localparam logic [1:0] BABS_ACK  = 2'b01;
    localparam logic [1:0] BABS_HALT = 2'b11;

    localparam logic [15:0] DEFAULT_RST_VEC_ADDR = 16'hFFFE;

endpackage

// File: rtl/m6809_sync2.sv
// Two-flop synchronizer with a synchronous active-low reset to a chosen value.
module m6809_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m6809_reset_halt_ctl.sv
// Reset-vector fetch, run gating and BA/BS halt handshake for the m6809 core.
// Defining M6809_HALT_SYNC_EN puts halt_b through a two-flop synchronizer.
//
// state     | meaning
// RESET     | held in reset, BA/BS=01
// VEC_HI/LO | one-cycle read strobe for vector high/low byte
// WAIT_HI/LO| memory latency countdown, capture byte on terminal count
// LOAD      | one-cycle PC load pulse
// RUN       | core advancing, BA/BS=00
// HALT_WAIT | halt requested, core runs to instruction boundary
// HALTED    | core stopped, BA/BS=11
module m6809_reset_halt_ctl
    import m6809_pkg::*;
#(
    parameter logic [15:0] RST_VEC_ADDR = DEFAULT_RST_VEC_ADDR,
    parameter int          MEM_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        halt_b,
    input  logic        inst_done,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic        rd,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        core_run,
    output logic        ba,
    output logic        bs
);

    localparam logic [1:0]  LAT_LAST    = 2'(MEM_LATENCY - 1);
    localparam logic [15:0] VEC_LO_ADDR = RST_VEC_ADDR + 16'd1;

    state_t      state, state_nxt;
    logic [1:0]  lat_cnt, lat_cnt_nxt;
    logic [15:0] pc_nxt, addr_nxt;
    logic        rd_nxt, pc_load_nxt, core_run_nxt;
    logic [1:0]  babs, babs_nxt;
    logic        halt_s;

`ifdef M6809_HALT_SYNC_EN
    m6809_sync2 #(.RST_VAL(1'b1)) u_halt_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       (halt_b),
        .q       (halt_s)
    );
`else
    assign halt_s = halt_b;
`endif

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state    <= S_RESET;
            lat_cnt  <= 2'd0;
            pc_value <= 16'h0000;
            addr     <= 16'h0000;
            rd       <= 1'b0;
            pc_load  <= 1'b0;
            core_run <= 1'b0;
            babs     <= BABS_ACK;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            pc_value <= pc_nxt;
            addr     <= addr_nxt;
            rd       <= rd_nxt;
            pc_load  <= pc_load_nxt;
            core_run <= core_run_nxt;
            babs     <= babs_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        pc_nxt      = pc_value;
        case (state)
            S_RESET:   state_nxt = S_VEC_HI;
            S_VEC_HI: begin
                state_nxt   = S_WAIT_HI;
                lat_cnt_nxt = LAT_LAST;
            end
            S_WAIT_HI: begin
                if (lat_cnt == 2'd0) begin
                    pc_nxt[15:8] = data_in;
                    state_nxt    = S_VEC_LO;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            S_VEC_LO: begin
                state_nxt   = S_WAIT_LO;
                lat_cnt_nxt = LAT_LAST;
            end
            S_WAIT_LO: begin
                if (lat_cnt == 2'd0) begin
                    pc_nxt[7:0] = data_in;
                    state_nxt   = S_LOAD;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            // the core sits at a boundary before its first instruction
            S_LOAD:    state_nxt = halt_s ? S_RUN : S_HALTED;
            S_RUN: begin
                if (!halt_s) state_nxt = inst_done ? S_HALTED : S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                if (inst_done)   state_nxt = S_HALTED;
                else if (halt_s) state_nxt = S_RUN;
            end
            S_HALTED: begin
                if (halt_s) state_nxt = S_RUN;
            end
            default:   state_nxt = S_RESET;
        endcase

        rd_nxt = (state_nxt == S_VEC_HI) || (state_nxt == S_VEC_LO);
        addr_nxt = 16'h0000;
        if (state_nxt == S_VEC_HI)      addr_nxt = RST_VEC_ADDR;
        else if (state_nxt == S_VEC_LO) addr_nxt = VEC_LO_ADDR;
        pc_load_nxt  = (state_nxt == S_LOAD);
        core_run_nxt = (state_nxt == S_RUN) || (state_nxt == S_HALT_WAIT);
        babs_nxt = BABS_ACK;
        if (state_nxt == S_HALTED) babs_nxt = BABS_HALT;
        else if (core_run_nxt)     babs_nxt = BABS_RUN;
    end

    assign ba = babs[1];
    assign bs = babs[0];

endmodule
